request_pending_latch: RTL and testbench
========================================

Name: request_pending_latch

Overview:
Upstream capture stage for the 8-to-3 priority encoder. Synchronizes eight asynchronous request lines and latches rising edges into sticky pending bits. Applies a programmable mask and drives the encoder's data_in/enable pair. The consumer returns a 3-bit clear index so that each serviced request is retired, and re-arrivals on a still-pending bit are flagged as overruns.

Parameters:
LEVEL_MODE, 0, 0 = rising-edge capture with sticky pending; 1 = pending follows the synchronized level, with clears and overruns ignored.
MASK_RESET, 8'hFF, reset value of the mask register.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; all registers cleared while low.
req_in  input  8  asynchronous request lines; bit 7 is highest priority downstream.
global_en  input  1  master enable; gates enable_out only.
mask_wr  input  1  write strobe for mask register.
mask_data  input  8  new mask value; 1 = request visible downstream.
clr_valid  input  1  clear strobe from the encoder consumer; always accepted.
clr_index  input  3  index of the pending bit to retire when clr_valid=1.
overrun_clr  input  1  clears all overrun bits.
data_out  output  8  registered (pending & mask); connects to encoder data_in.
enable_out  output  1  registered global_en & |(pending & mask); connects to encoder enable.
overrun  output  8  sticky per-bit overrun flags.
pend_count  output  4  registered popcount of pending, 0..8, unmasked.

Behaviour:
- Reset (reset=0, async): sync1/sync2/prev=0, pending=0, mask=MASK_RESET, overrun=0, data_out=0, enable_out=0, pend_count=0. Deassertion is sampled on the next rising clk edge.
- Synchronizer per bit: sync1<=req_in; sync2<=sync1; prev<=sync2. rise[i]=sync2[i]&~prev[i].
- Latency (edge mode): req_in rises before edge E0, so sync1 is high at E0 and sync2 at E1, and rise is valid between E1 and E2. pending is set at E2; data_out, enable_out and pend_count update at E3. Total latency is 3 clocks from E0.
- Pending update (edge mode), per bit i, at each edge:
  - set_i = rise[i]; clr_i = clr_valid && clr_index==i.
  - set_i=1: pending<=1, whether or not clr_i is asserted. Set wins.
  - set_i=0, clr_i=1: pending<=0.
  - Otherwise pending holds.
  - Clearing a bit that is not pending has no effect.
- Overrun (edge mode): overrun[i]<=1 when rise[i]=1 and pending[i]=1 and clr_i=0 in the same cycle. overrun_clr=1 zeroes all overrun bits except those being newly set in that cycle; set wins. Bits are sticky otherwise.
- Level mode: pending<=sync2 every cycle. clr_valid and clr_index are ignored. overrun stays 0. Latency to data_out is 2 clocks from E0.
- Mask:
  - mask_wr=1 loads mask_data at the edge.
  - The mask affects data_out and enable_out only. Masked requests are still captured into pending and counted.
  - Unmasking an already-pending bit makes it visible on data_out one clock after the mask write edge.
- Outputs are registered from the current pending and mask: data_out<=pending&mask; enable_out<=global_en & |(pending&mask); pend_count<=popcount(pending).
- global_en=0 forces enable_out to 0 one clock later. data_out keeps tracking pending and mask.
- Simultaneous events in one cycle (rise on several bits, a clear on a different bit, mask write) are all applied independently in that cycle.
- If reset is asserted mid-operation, all pending and overrun state is lost immediately, with no clock required.
- All widths are fixed at 8 to match the encoder. pend_count saturates naturally at 8, so no wrap is possible.

Test Plan:
1. Reset with reset=0 and req_in=8'hA5 -> all outputs 0 while reset is low. After release, req_in=8'h00 for 4 clocks -> data_out=0, enable_out=0, pend_count=0.
2. global_en=1; pulse req_in[5] high for 1 clock, sampled at E0 -> data_out=8'h20, enable_out=1 and pend_count=1 after E3. Then clr_valid=1, clr_index=5 for one clock -> data_out=0, enable_out=0 two clocks later.
3. req_in=8'h81 edge, then mask_wr with mask_data=8'h7F -> data_out=8'h01 and pend_count=2. Write mask_data=8'hFF -> data_out=8'h81 one clock after the write.
4. Bit 2 pending; re-pulse req_in[2] without a clear -> overrun=8'h04 and pend_count stays 1. Assert overrun_clr -> overrun=0. Repeat with clr_valid, clr_index=2 in the same cycle as rise -> pending stays 1 and overrun stays 0.
5. Pending=8'hFF (all eight edges), global_en=0 -> data_out=8'hFF, enable_out=0, pend_count=8. Set global_en=1 -> enable_out=1 the next clock. Assert reset mid-stream -> all outputs 0 immediately.
6. LEVEL_MODE=1: hold req_in=8'h30 -> data_out=8'h30 after 2 clocks; clr_valid with clr_index=4 has no effect. Drop req_in to 0 -> data_out=0 after 2 clocks, and overrun stays 0 throughout.

Source files
------------

// File: rtl/request_pending_latch.sv
// Capture stage ahead of the 8-to-3 priority encoder: synchronizes request lines,
// latches rising edges as sticky pending bits, masks them and retires serviced bits.
module request_pending_latch #(
  parameter bit         LEVEL_MODE = 1'b0,
  parameter logic [7:0] MASK_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req_in,
  input  logic       global_en,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  input  logic       clr_valid,
  input  logic [2:0] clr_index,
  input  logic       overrun_clr,
  output logic [7:0] data_out,
  output logic       enable_out,
  output logic [7:0] overrun,
  output logic [3:0] pend_count
);

  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] prev;
  logic [7:0] pending;
  logic [7:0] mask;

  logic [7:0] rise;
  logic [7:0] clr_vec;
  logic [7:0] pending_next;
  logic [7:0] overrun_next;
  logic [7:0] visible;
  logic [7:0] masked;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  assign rise = sync2 & ~prev;

  // NOTE: every signal assigned in always_comb gets a default first so no path
  // leaves it unassigned; a missing default infers a latch.
  always_comb begin
    clr_vec = 8'h00;
    if (clr_valid) begin
      clr_vec[clr_index] = 1'b1;
    end
  end

  // Set dominates clear, so a request arriving while its own clear is in flight
  // is never lost. An arrival on an uncleared pending bit is an overrun.
  always_comb begin
    pending_next = pending;
    overrun_next = overrun;
    if (LEVEL_MODE) begin
      pending_next = sync2;
      overrun_next = 8'h00;
    end else begin
      pending_next = rise | (pending & ~clr_vec);
      overrun_next = (rise & pending & ~clr_vec) | (overrun_clr ? 8'h00 : overrun);
    end
  end

  // Level mode presents the synchronized level directly, one clock earlier than
  // the edge path, which needs the extra prev stage to detect the rise.
  assign visible = LEVEL_MODE ? sync2 : pending;
  assign masked  = visible & mask;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= 8'h00;
      sync2      <= 8'h00;
      prev       <= 8'h00;
      pending    <= 8'h00;
      mask       <= MASK_RESET;
      overrun    <= 8'h00;
      data_out   <= 8'h00;
      enable_out <= 1'b0;
      pend_count <= 4'd0;
    end else begin
      sync1      <= req_in;
      sync2      <= sync1;
      prev       <= sync2;
      pending    <= pending_next;
      overrun    <= overrun_next;
      if (mask_wr) begin
        mask <= mask_data;
      end
      data_out   <= masked;
      enable_out <= global_en & (|masked);
      pend_count <= popcount8(visible);
    end
  end

endmodule

// File: tb/tb_request_pending_latch.sv
// Directed bench for request_pending_latch: an edge-mode and a level-mode instance,
// expectations queued as stimulus is driven and checked when the outputs settle.
module tb_request_pending_latch;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req_in;
  logic [7:0] req_lv;
  logic       global_en;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic       clr_valid;
  logic [2:0] clr_index;
  logic       overrun_clr;

  logic [7:0] data_out,   data_out_lv;
  logic       enable_out, enable_out_lv;
  logic [7:0] overrun,    overrun_lv;
  logic [3:0] pend_count, pend_count_lv;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    bit         lv;
    logic [7:0] d;
    logic       e;
    logic [7:0] o;
    logic [3:0] c;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  request_pending_latch #(.LEVEL_MODE(1'b0), .MASK_RESET(8'hFF)) dut_edge (
    .clk        (clk),
    .reset      (reset),
    .req_in     (req_in),
    .global_en  (global_en),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .clr_valid  (clr_valid),
    .clr_index  (clr_index),
    .overrun_clr(overrun_clr),
    .data_out   (data_out),
    .enable_out (enable_out),
    .overrun    (overrun),
    .pend_count (pend_count)
  );

  request_pending_latch #(.LEVEL_MODE(1'b1), .MASK_RESET(8'hFF)) dut_level (
    .clk        (clk),
    .reset      (reset),
    .req_in     (req_lv),
    .global_en  (global_en),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .clr_valid  (clr_valid),
    .clr_index  (clr_index),
    .overrun_clr(overrun_clr),
    .data_out   (data_out_lv),
    .enable_out (enable_out_lv),
    .overrun    (overrun_lv),
    .pend_count (pend_count_lv)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input bit lv, input logic [7:0] d,
                            input logic e, input logic [7:0] o, input logic [3:0] c);
    exp_t x;
    x.tag = tag; x.lv = lv; x.d = d; x.e = e; x.o = o; x.c = c;
    sb.push_back(x);
  endtask

  task automatic compare();
    exp_t x;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty: observed no entry expected one");
    end else begin
      x = sb.pop_front();
      if (x.lv) begin
        check({x.tag, ".data"},  data_out_lv,            x.d);
        check({x.tag, ".en"},    {7'd0, enable_out_lv},  {7'd0, x.e});
        check({x.tag, ".ovr"},   overrun_lv,             x.o);
        check({x.tag, ".count"}, {4'd0, pend_count_lv},  {4'd0, x.c});
      end else begin
        check({x.tag, ".data"},  data_out,               x.d);
        check({x.tag, ".en"},    {7'd0, enable_out},     {7'd0, x.e});
        check({x.tag, ".ovr"},   overrun,                x.o);
        check({x.tag, ".count"}, {4'd0, pend_count},     {4'd0, x.c});
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset held with requests active: everything must read zero.
    reset = 1'b0; req_in = 8'hA5; req_lv = 8'hA5; global_en = 1'b0;
    mask_wr = 1'b0; mask_data = 8'h00; clr_valid = 1'b0; clr_index = 3'd0;
    overrun_clr = 1'b0;
    expect_out("rst_edge", 1'b0, 8'h00, 1'b0, 8'h00, 4'd0);
    expect_out("rst_lvl",  1'b1, 8'h00, 1'b0, 8'h00, 4'd0);
    cyc(2);
    compare(); compare();
    reset = 1'b1; req_in = 8'h00; req_lv = 8'h00;
    expect_out("idle_edge", 1'b0, 8'h00, 1'b0, 8'h00, 4'd0);
    expect_out("idle_lvl",  1'b1, 8'h00, 1'b0, 8'h00, 4'd0);
    cyc(4);
    compare(); compare();

    // Single pulse on bit 5: not visible after E2, visible after E3.
    global_en = 1'b1;
    req_in = 8'h20;
    expect_out("pulse5_e2", 1'b0, 8'h00, 1'b0, 8'h00, 4'd0);
    expect_out("pulse5_e3", 1'b0, 8'h20, 1'b1, 8'h00, 4'd1);
    cyc(1); req_in = 8'h00;
    cyc(2); compare();
    cyc(1); compare();
    clr_valid = 1'b1; clr_index = 3'd5;
    expect_out("clear5", 1'b0, 8'h00, 1'b0, 8'h00, 4'd0);
    cyc(1); clr_valid = 1'b0;
    cyc(1); compare();

    // Masked bit still counted; unmask shows one clock after the write edge.
    req_in = 8'h81;
    cyc(1); req_in = 8'h00;
    cyc(2);
    mask_wr = 1'b1; mask_data = 8'h7F;
    expect_out("mask7f", 1'b0, 8'h01, 1'b1, 8'h00, 4'd2);
    cyc(1); mask_wr = 1'b0;
    cyc(1); compare();
    mask_wr = 1'b1; mask_data = 8'hFF;
    expect_out("unmask_edge", 1'b0, 8'h01, 1'b1, 8'h00, 4'd2);
    expect_out("unmask_next", 1'b0, 8'h81, 1'b1, 8'h00, 4'd2);
    cyc(1); mask_wr = 1'b0; compare();
    cyc(1); compare();
    clr_valid = 1'b1; clr_index = 3'd7;
    cyc(1); clr_index = 3'd0;
    cyc(1); clr_valid = 1'b0;
    expect_out("clear81", 1'b0, 8'h00, 1'b0, 8'h00, 4'd0);
    cyc(1); compare();

    // Overrun on bit 2, then overrun_clr, then rise coinciding with its clear.
    req_in = 8'h04;
    cyc(1); req_in = 8'h00;
    expect_out("pend2", 1'b0, 8'h04, 1'b1, 8'h00, 4'd1);
    cyc(3); compare();
    req_in = 8'h04;
    cyc(1); req_in = 8'h00;
    expect_out("ovr2", 1'b0, 8'h04, 1'b1, 8'h04, 4'd1);
    cyc(2); compare();
    overrun_clr = 1'b1;
    expect_out("ovr_clr", 1'b0, 8'h04, 1'b1, 8'h00, 4'd1);
    cyc(1); overrun_clr = 1'b0; compare();
    req_in = 8'h04;
    cyc(1); req_in = 8'h00;
    cyc(1); clr_valid = 1'b1; clr_index = 3'd2;
    expect_out("set_wins", 1'b0, 8'h04, 1'b1, 8'h00, 4'd1);
    cyc(1); clr_valid = 1'b0;
    cyc(1); compare();
    clr_valid = 1'b1; clr_index = 3'd2;
    expect_out("clear2", 1'b0, 8'h00, 1'b0, 8'h00, 4'd0);
    cyc(1); clr_valid = 1'b0;
    cyc(1); compare();

    // All eight pending with global_en low, then enable, overrun, async reset.
    global_en = 1'b0; req_in = 8'hFF;
    cyc(1); req_in = 8'h00;
    expect_out("all_gated", 1'b0, 8'hFF, 1'b0, 8'h00, 4'd8);
    cyc(3); compare();
    global_en = 1'b1;
    expect_out("all_enabled", 1'b0, 8'hFF, 1'b1, 8'h00, 4'd8);
    cyc(1); compare();
    req_in = 8'h01;
    cyc(1); req_in = 8'h00;
    expect_out("ovr0", 1'b0, 8'hFF, 1'b1, 8'h01, 4'd8);
    cyc(2); compare();
    #2 reset = 1'b0;
    expect_out("async_rst_edge", 1'b0, 8'h00, 1'b0, 8'h00, 4'd0);
    expect_out("async_rst_lvl",  1'b1, 8'h00, 1'b0, 8'h00, 4'd0);
    #1 compare(); compare();
    cyc(1); reset = 1'b1;
    cyc(2);

    // Level mode: 2-clock latency, clears ignored, no overruns.
    req_lv = 8'h30;
    expect_out("lvl_e1", 1'b1, 8'h00, 1'b0, 8'h00, 4'd0);
    expect_out("lvl_e2", 1'b1, 8'h30, 1'b1, 8'h00, 4'd2);
    cyc(2); compare();
    cyc(1); compare();
    clr_valid = 1'b1; clr_index = 3'd4;
    expect_out("lvl_clr_ignored", 1'b1, 8'h30, 1'b1, 8'h00, 4'd2);
    cyc(1); clr_valid = 1'b0;
    cyc(1); compare();
    req_lv = 8'h00;
    expect_out("lvl_drop_e1", 1'b1, 8'h30, 1'b1, 8'h00, 4'd2);
    expect_out("lvl_drop_e2", 1'b1, 8'h00, 1'b0, 8'h00, 4'd0);
    cyc(2); compare();
    cyc(1); compare();

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
